// File: rtl/keypad_scan_ctrl_if.sv
// Key event handshake bundle for keypad_scan_ctrl.
//   evt_valid : producer -> consumer, head event present
//   evt_code  : producer -> consumer, {press, key[3:0]} of the head event
//   evt_ready : consumer -> producer, accepts the head event when high with evt_valid
interface keypad_scan_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [4:0] evt_code;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with scan-level debounce and a 4-deep event FIFO.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   en            : scan enable (low forces IDLE)
//   col           : asynchronous column sense lines, active-high
//   row           : one-hot row drive, zero when not driving
//   evt           : event handshake (valid/ready/code), first-word fall-through
//   irq           : level interrupt, mirrors evt_valid
//   overflow      : sticky dropped-event flag, cleared by ovf_clr
module keypad_scan_ctrl #(
    parameter int unsigned ROW_DWELL = 1000,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      en,
    input  logic [3:0]                col,
    output logic [3:0]                row,
    keypad_scan_ctrl_if.master        evt,
    output logic                      irq,
    output logic                      overflow,
    input  logic                      ovf_clr
);

    typedef enum logic [1:0] {IDLE, DRIVE, EVAL, EMIT} state_t;

    localparam logic [15:0] DWELL_LAST = 16'(ROW_DWELL - 1);
    localparam logic [3:0]  DEB_MAX    = 4'(DEB_SCANS);

    state_t      state_q;
    logic [3:0]  col_s1_q, col_s2_q;
    logic [1:0]  idx_q;
    logic [15:0] dwell_q;
    logic [3:0]  row_q;
    logic [15:0] snap_q, prev_q, deb_q;
    logic [3:0]  stable_q;

    logic [4:0]  mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  cnt_q;
    logic        ovf_q;

    logic [3:0]  stable_d;
    logic [15:0] diff;
    logic [3:0]  emit_idx;
    logic        emit_found;
    logic        emit_last;
    logic        push;
    logic [4:0]  push_code;
    logic        valid;
    logic        pop, full, do_push, drop;

    always_comb begin
        stable_d = 4'd1;
        if (snap_q == prev_q)
            stable_d = (stable_q >= DEB_MAX) ? DEB_MAX : stable_q + 4'd1;
    end

    // Lowest changed key is emitted first; emit_last marks the final one.
    always_comb begin
        diff       = snap_q ^ deb_q;
        emit_idx   = '0;
        emit_found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (diff[i] && !emit_found) begin
                emit_idx   = 4'(i);
                emit_found = 1'b1;
            end
        end
        emit_last = ((diff & (diff - 16'd1)) == '0);
        push      = (state_q == EMIT) && en;
        push_code = {snap_q[emit_idx], emit_idx};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_s1_q <= '0;
            col_s2_q <= '0;
        end else begin
            col_s1_q <= col;
            col_s2_q <= col_s1_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dwell_q  <= '0;
            row_q    <= '0;
            snap_q   <= '0;
            prev_q   <= '0;
            deb_q    <= '0;
            stable_q <= '0;
        end else if (!en) begin
            // debounced and prev_scan survive so a resumed scan compares against history
            state_q  <= IDLE;
            idx_q    <= '0;
            dwell_q  <= '0;
            row_q    <= '0;
            snap_q   <= '0;
            stable_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= DRIVE;
                    idx_q   <= '0;
                    dwell_q <= '0;
                    row_q   <= 4'b0001;
                end
                DRIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        snap_q[{idx_q, 2'b00} +: 4] <= col_s2_q;
                        dwell_q <= '0;
                        if (idx_q == 2'd3) begin
                            state_q <= EVAL;
                            row_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                            row_q <= row_q << 1;
                        end
                    end else begin
                        dwell_q <= dwell_q + 16'd1;
                    end
                end
                EVAL: begin
                    stable_q <= stable_d;
                    prev_q   <= snap_q;
                    if (stable_d == DEB_MAX && snap_q != deb_q) begin
                        state_q <= EMIT;
                    end else begin
                        state_q <= DRIVE;
                        idx_q   <= '0;
                        dwell_q <= '0;
                        row_q   <= 4'b0001;
                    end
                end
                EMIT: begin
                    // debounced follows the emitted key even if the FIFO drops the event
                    deb_q[emit_idx] <= snap_q[emit_idx];
                    if (emit_last) begin
                        state_q <= DRIVE;
                        idx_q   <= '0;
                        dwell_q <= '0;
                        row_q   <= 4'b0001;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid   = (cnt_q != 3'd0);
    assign full    = (cnt_q == 3'd4);
    assign pop     = valid && evt.evt_ready;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_code;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q <= cnt_q + {2'b00, do_push} - {2'b00, pop};
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign row           = row_q;
    assign evt.evt_valid = valid;
    assign evt.evt_code  = mem_q[rd_ptr_q];
    assign irq           = valid;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a behavioural keypad drives col from row,
// expected events are queued when key sets change and popped by a monitor.
module tb_keypad_scan_ctrl;
    localparam int unsigned RD   = 4;
    localparam int unsigned DS   = 2;
    localparam int unsigned SCAN = 4 * RD + 1;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [3:0]  col, row;
    logic        irq, overflow;
    logic [15:0] keys = '0;

    keypad_scan_ctrl_if evt_if();

    keypad_scan_ctrl #(.ROW_DWELL(RD), .DEB_SCANS(DS)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .en       (en),
        .col      (col),
        .row      (row),
        .evt      (evt_if),
        .irq      (irq),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 HCLK = ~HCLK;

    // Physical keypad: column c reads high if any driven row has key row*4+c closed.
    always_comb begin
        col = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (row[r] && keys[r*4+c]) col[c] = 1'b1;
    end

    logic [4:0]  sbq[$];
    int          pop_cyc[$];
    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          rdy_mode = 0;   // 0 hold off, 1 always ready, 2 random
    logic [15:0] m_deb = '0;
    logic        m_ovf = 1'b0;

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic wait_row(input logic [3:0] val, input string name);
        int n = 0;
        while (row !== val && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        if (row !== val) fail_now(name);
    endtask

    // Reference: a change to a held key set yields one event per changed key,
    // ascending index; a full FIFO with no consumer drops the event.
    task automatic expect_keys(input logic [15:0] nk);
        logic [15:0] d = nk ^ m_deb;
        for (int k = 0; k < 16; k++) begin
            if (d[k]) begin
                if (rdy_mode == 0 && sbq.size() >= 4) m_ovf = 1'b1;
                else sbq.push_back({nk[k], 4'(k)});
            end
        end
        m_deb = nk;
    endtask

    task automatic apply(input logic [15:0] nk, input int hold);
        expect_keys(nk);
        keys = nk;
        tick(hold);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sbq.size() != 0 || evt_if.evt_valid) && n < 1000) begin
            @(negedge HCLK);
            n++;
        end
        check(name, sbq.size(), 0);
    endtask

    // Monitor: owns evt_ready, compares each accepted event against the queue head.
    initial begin
        logic r;
        logic [4:0] e;
        evt_if.evt_ready = 1'b0;
        forever begin
            @(negedge HCLK);
            if (HRESETn) begin
                check("irq_eq_valid", irq, evt_if.evt_valid);
                r = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
                evt_if.evt_ready = r;
                if (evt_if.evt_valid && r) begin
                    if (sbq.size() == 0) begin
                        nchk++;
                        nerr++;
                        $display("FAIL unexpected_event: got %0h expected none", evt_if.evt_code);
                    end else begin
                        e = sbq.pop_front();
                        check("evt_code", evt_if.evt_code, e);
                    end
                    pop_cyc.push_back(cyc);
                end
            end else begin
                evt_if.evt_ready = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] er;
        logic [15:0] nk;

        // reset values
        tick(3);
        check("rst_row", row, 0);
        check("rst_valid", evt_if.evt_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_code", evt_if.evt_code, 0);
        check("rst_ovf", overflow, 0);
        HRESETn = 1'b1;
        tick(2);
        check("idle_row", row, 0);

        // row walk, no keys
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < int'(SCAN); s++) begin
                @(negedge HCLK);
                er = (s < int'(4 * RD)) ? 4'(1 << (s / int'(RD))) : 4'b0000;
                check("row_walk", row, er);
                check("walk_no_evt", evt_if.evt_valid, 0);
            end
        end
        en = 1'b0;
        tick(2);

        // single press of key 6 from enable
        rdy_mode = 0;
        expect_keys(16'h0040);
        keys = 16'h0040;
        en = 1'b1;
        n = 0;
        while (!evt_if.evt_valid && n < 40) begin
            @(negedge HCLK);
            n++;
        end
        check("press_within_40", evt_if.evt_valid, 1);
        check("press_code", evt_if.evt_code, 5'h16);
        tick(5);
        check("irq_held", irq, 1);
        rdy_mode = 1;
        drain("drain_press");

        // release 6, press 0 and 15 together
        pop_cyc.delete();
        apply(16'h8001, 8 * SCAN);
        drain("drain_multi");
        check("multi_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("multi_consec1", pop_cyc[1] - pop_cyc[0], 1);
            check("multi_consec2", pop_cyc[2] - pop_cyc[1], 1);
        end

        // key 3 toggled once per scan, between scans
        for (int i = 0; i < 6; i++) begin
            wait_row(4'b1000, "bounce_wait_r3");
            wait_row(4'b0000, "bounce_wait_eval");
            keys[3] = ~keys[3];
        end
        tick(6 * SCAN);
        check("bounce_no_evt", evt_if.evt_valid, 0);

        // overflow with no consumer
        rdy_mode = 0;
        apply(keys | 16'h0002, 5 * SCAN);
        apply(keys | 16'h0004, 5 * SCAN);
        apply(keys | 16'h0010, 5 * SCAN);
        apply(keys | 16'h0020, 5 * SCAN);
        check("ovf_before", overflow, m_ovf);
        check("full_valid", evt_if.evt_valid, 1);
        apply(keys | 16'h0080, 5 * SCAN);
        check("ovf_set", overflow, m_ovf);
        ovf_clr = 1'b1;
        @(negedge HCLK);
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        rdy_mode = 1;
        drain("drain_ovf");

        // abort during row 2
        rdy_mode = 0;
        apply(keys | 16'h0200, 5 * SCAN);
        wait_row(4'b0100, "abort_wait_r2");
        tick(1);
        en = 1'b0;
        @(negedge HCLK);
        check("abort_row", row, 0);
        check("abort_valid", evt_if.evt_valid, 1);
        if (sbq.size() > 0) check("abort_head", evt_if.evt_code, sbq[0]);
        tick(3);
        en = 1'b1;
        @(negedge HCLK);
        check("restart_row", row, 4'b0001);
        rdy_mode = 1;
        drain("drain_abort");

        // random key changes with random backpressure
        rdy_mode = 2;
        for (int it = 0; it < 10; it++) begin
            nk = keys;
            repeat ($urandom_range(1, 3)) nk[$urandom_range(0, 15)] ^= 1'b1;
            apply(nk, 8 * SCAN);
            drain("drain_rand");
        end

        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter ROW_DWELL, default 1000, HCLK cycles each row is driven per scan step; legal range 3..65535.
REQ-002 Parameter DEB_SCANS, default 4, consecutive identical full scans required to commit a key change; legal range 1..15.
REQ-003 HCLK  input  1  system clock; all state changes on its rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  scan enable; low holds the scanner idle.
REQ-006 col  input  4  column sense lines, asynchronous, active-high (1 = key closed on the driven row).
REQ-007 row  output  4  row drive, one-hot active-high; all zero when idle.
REQ-008 evt_valid  output  1  event FIFO non-empty; evt_code is valid.
REQ-009 evt_ready  input  1  consumer accepts the head event when high together with evt_valid.
REQ-010 evt_code  output  5  {press, key[3:0]}; press 1 = closed, 0 = opened; key = row*4 + col index.
REQ-011 irq  output  1  level interrupt, equal to evt_valid.
REQ-012 overflow  output  1  sticky flag, set when an event is dropped.
REQ-013 ovf_clr  input  1  single-cycle clear of overflow.

Function
REQ-014 col SHALL pass through a 2-flop synchronizer before any use.
REQ-015 The FSM SHALL have states IDLE, DRIVE, EVAL and EMIT.
REQ-016 IDLE: row = 0; when en = 1, go to DRIVE with row index 0 and dwell counter 0.
REQ-017 DRIVE: row[idx] = 1 for exactly ROW_DWELL cycles.
REQ-018 DRIVE sampling: on the last dwell cycle, the synchronized col is written to snapshot[idx*4+3 : idx*4].
REQ-019 DRIVE exit: idx advances 0→1→2→3; after idx 3, go to EVAL (row = 0 in EVAL and EMIT).
REQ-020 EVAL, stability count: if snapshot == prev_scan, stable_cnt increments, saturating at DEB_SCANS; otherwise stable_cnt = 1; then prev_scan = snapshot.
REQ-021 EVAL, commit: if stable_cnt (post-update) == DEB_SCANS and snapshot != debounced, go to EMIT; otherwise go to DRIVE with idx 0.
REQ-022 EMIT SHALL push one event per cycle for each bit where snapshot differs from debounced, lowest key index first.
REQ-023 EMIT SHALL update each key's debounced bit as its event is emitted, then return to DRIVE with idx 0; at most 16 cycles are spent in EMIT.
REQ-024 Event FIFO: depth 4, first-word fall-through; evt_code shows the head entry; a pop occurs when evt_valid & evt_ready.
REQ-025 FIFO full: a push with no simultaneous pop SHALL drop the event and set overflow; debounced SHALL still update.
REQ-026 FIFO full with simultaneous push and pop: both SHALL occur and the occupancy stays 4; no overflow.
REQ-027 Empty FIFO: evt_ready SHALL be ignored; occupancy never underflows.
REQ-028 overflow set and ovf_clr in the same cycle: set wins.
REQ-029 en = 0 in any state: go to IDLE next cycle.
REQ-030 On entering IDLE, row = 0 and dwell counter, idx, snapshot and stable_cnt SHALL clear.
REQ-031 On entering IDLE, debounced, prev_scan, FIFO contents and overflow SHALL be retained.
REQ-032 An EMIT sequence interrupted by en = 0 SHALL leave the remaining keys un-emitted; they are re-detected after scanning resumes.

Reset
REQ-033 While HRESETn = 0: row = 0, evt_valid = 0, irq = 0, evt_code = 0, overflow = 0.
REQ-034 While HRESETn = 0: FSM in IDLE; snapshot, prev_scan and debounced = 16'h0000; stable_cnt = 0; FIFO empty; synchronizer flops = 0.
REQ-035 Reset assertion mid-scan or mid-EMIT SHALL take effect immediately and discard any pending events.

Verification (ROW_DWELL=4, DEB_SCANS=2)
REQ-036 Check row sequencing: en = 1, no keys held -> row walks 0001, 0010, 0100, 1000 with 4 cycles each plus 1 EVAL cycle, and repeats; no events.
REQ-037 Check a single press: key 6 held (col[2] high while row[1] driven) from en rise -> exactly one event 5'h16 within 40 cycles; irq = 1 until popped with evt_ready.
REQ-038 Check release and multi-key order: release key 6 and press keys 0 and 15 simultaneously -> events 5'h10, 5'h06, 5'h1F, in that order, on consecutive EMIT cycles.
REQ-039 Check bounce rejection: key 3 toggled every scan for 6 scans -> no event.
REQ-040 Check overflow: evt_ready = 0, 5 distinct presses -> FIFO holds the first 4 events, overflow = 1; ovf_clr pulse -> overflow = 0.
REQ-041 Check abort: en dropped during the DRIVE of row 2 -> row = 0 next cycle, FIFO unchanged; en re-raised -> scanning restarts at row 0001.
